// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage load/store engine: FSM states, funct3 codes,
// byte-enable patterns and the size/offset helpers used by the sub-word build.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic [3:0] {
    BE_BYTE = 4'b0001,
    BE_HALF = 4'b0011,
    BE_WORD = 4'b1111
  } be_pat_t;

  // size is funct3[1:0]; the reserved size code is treated as a word
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'(BE_BYTE) << off;
      2'b01:   return 4'(BE_HALF) << off;
      default: return 4'(BE_WORD);
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack port; master is the load/store engine, slave is the memory.
interface mem_access_unit_if #(parameter int DATA_W = 32);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/load_align.sv
// Load lane extraction and sign/zero extension; only present in the sub-word build.
`ifdef MEM_SUBWORD_EN
module load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{off, 3'b000} +: 8];
    h    = rdata[{off[1], 4'b0000} +: 16];
    data = rdata;
    case (funct3)
      F3_B:    data = {{(DATA_W-8){b[7]}}, b};
      F3_BU:   data = {{(DATA_W-8){1'b0}}, b};
      F3_H:    data = {{(DATA_W-16){h[15]}}, h};
      F3_HU:   data = {{(DATA_W-16){1'b0}}, h};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data-memory access with pipeline stall and timeout.
// Define MEM_SUBWORD_EN for byte/half accesses; default build is word-only.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass straight through
// REQ   | request on the data port, waiting for ack or timeout
// DONE  | result presented to MEM/WB, stall released for one cycle
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic [4:0]        RDaddr_i,
  mem_access_unit_if.master dmem,
  output logic              stall_o,
  output logic              err_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [4:0]        RDaddr_o,
  output logic [DATA_W-1:0] Memdata_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [DATA_W-1:0] addr_d, wdata_d, load_data;
  logic [3:0]        be_q, be_d;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fail_q;
  logic              access, misalign, timeout_hit;

  assign access      = MemRead_i | MemWrite_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_SUBWORD_EN
  logic [2:0] funct3_q;

  assign misalign = misaligned(funct3_i[1:0], ALUResult_i[1:0]);
  assign be_d     = be_for(funct3_i[1:0], ALUResult_i[1:0]);
  assign addr_d   = ALUResult_i;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wdata_d = {(DATA_W/8){WriteData_i[7:0]}};
      2'b01:   wdata_d = {(DATA_W/16){WriteData_i[15:0]}};
      default: wdata_d = WriteData_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         funct3_q <= 3'b000;
    else if (state_q == IDLE && access)   funct3_q <= funct3_i;
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata  (dmem.rdata),
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );
`else
  logic unused_funct3;

  assign unused_funct3 = ^funct3_i;
  assign misalign      = 1'b0;
  assign be_d          = 4'(BE_WORD);
  assign addr_d        = {ALUResult_i[DATA_W-1:2], 2'b00};
  assign wdata_d       = WriteData_i;
  assign load_data     = dmem.rdata;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access) state_d = misalign ? DONE : REQ;
      REQ:     if (dmem.ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= 1'b0;
      case (state_q)
        IDLE: if (access) begin
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          be_q    <= be_d;
          we_q    <= MemWrite_i;
          cnt_q   <= '0;
          rdata_q <= '0;
          fail_q  <= misalign;
        end
        // ack has priority over a timeout landing on the same cycle
        REQ: if (dmem.ack) begin
          if (!we_q) rdata_q <= load_data;
        end else if (timeout_hit) begin
          fail_q  <= 1'b1;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dmem.req   = (state_q == REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

  assign stall_o     = rst_n_i & (((state_q == IDLE) & access) | (state_q == REQ));
  assign err_o       = fail_q;
  assign Memdata_o   = rdata_q;
  assign RegWrite_o  = RegWrite_i & ~fail_q;
  assign MemtoReg_o  = MemtoReg_i;
  assign ALUResult_o = ALUResult_i;
  assign RDaddr_o    = RDaddr_i;

endmodule
